rhd2000_sequencer: RTL

//  Schedules the RHD2000 SPI master: issues one sync pulse and a 16-bit command per transaction slot.
//  A frame is NUM_CH CONVERT slots (ch 0..NUM_CH-1) followed by NUM_AUX aux slots. Aux slots carry a

---
 rtl/rhd2000_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rhd2000_sequencer.sv
// Purpose: slot scheduler for one RHD2000 SPI master. It sends a sync pulse and a command in every
//          slot, and it retires each reply against the command issued two slots earlier.
// Latency: first sync 1 cycle after enable_i is sampled; reply outputs 1 cycle after capture.
// Backpressure: 1-deep host mailbox (valid/ready); there is no backpressure on the sample or reply outputs.
// Ports: clk_i/reset_n_i          clock and async active-low reset
//        enable_i                  run frames back-to-back while high
//        spi_cmd_o/spi_sync_o      command word and start pulse to the SPI master
//        spi_reply_i               reply word from the SPI master
//        host_cmd_*                mailbox write side (16-bit command, valid/ready)
//        host_reply_*, sample_*    retired replies (1-cycle valid pulses)
//        frame_start_o, frame_cnt_o, busy_o   frame status
module rhd2000_sequencer #(
  parameter int          NUM_CH      = 32,
  parameter int          NUM_AUX     = 3,
  parameter int          SLOT_CYCLES = 36,
  parameter logic [15:0] DUMMY_CMD   = 16'hFF00
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  output logic [15:0] spi_cmd_o,
  output logic        spi_sync_o,
  input  logic [15:0] spi_reply_i,
  input  logic [15:0] host_cmd_i,
  input  logic        host_cmd_valid_i,
  output logic        host_cmd_ready_o,
  output logic [15:0] host_reply_o,
  output logic        host_reply_valid_o,
  output logic [15:0] sample_o,
  output logic [5:0]  sample_ch_o,
  output logic        sample_valid_o,
  output logic        frame_start_o,
  output logic [31:0] frame_cnt_o,
  output logic        busy_o
);

  localparam int NSLOT = NUM_CH + NUM_AUX;
  localparam int SW    = $clog2(NSLOT);
  localparam int CW    = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC   = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(NSLOT - 1);
  localparam logic [SW-1:0] NUM_CH_S   = SW'(NUM_CH);
  localparam logic [SW-1:0] FLUSH_LAST = SW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;
  typedef enum logic [1:0] {K_CONV, K_HOST, K_DUMMY} kind_e;
  typedef struct packed {
    logic       vld;
    kind_e      kind;
    logic [5:0] ch;
  } tag_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   cmd_q, cmd_d;
  // tag_cur is the slot in flight; tag_h1 is two slots back and is the slot the current capture answers.
  tag_t          tag_cur_q, tag_cur_d, tag_h0_q, tag_h0_d, tag_h1_q, tag_h1_d;
  logic          mbox_full_q, mbox_full_d;
  logic [15:0]   mbox_q, mbox_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   sample_q, sample_d;
  logic [5:0]    sample_ch_q, sample_ch_d;
  logic          sample_vld_q, sample_vld_d;
  logic [15:0]   host_reply_q, host_reply_d;
  logic          host_reply_vld_q, host_reply_vld_d;

  logic          active, slot_start, slot_end, in_conv, take_host;
  logic [5:0]    slot_ch;
  kind_e         sel_kind;
  logic [15:0]   sel_cmd;

  assign active     = (state_q != S_IDLE);
  assign slot_start = active && (cyc_q == '0);
  assign slot_end   = active && (cyc_q == LAST_CYC);
  assign in_conv    = (state_q == S_RUN) && (slot_q < NUM_CH_S);
  assign take_host  = (state_q == S_RUN) && !in_conv && mbox_full_q;
  assign slot_ch    = 6'(slot_q);

  // The command is chosen combinationally in c=0, so it appears together with the sync pulse.
  // It is held in cmd_q for the remainder of the slot.
  always_comb begin
    sel_kind = K_DUMMY;
    sel_cmd  = DUMMY_CMD;
    if (in_conv) begin
      sel_kind = K_CONV;
      sel_cmd  = {2'b00, slot_ch, 8'h00};
    end else if (take_host) begin
      sel_kind = K_HOST;
      sel_cmd  = mbox_q;
    end
  end

  always_comb begin
    state_d          = state_q;
    cyc_d            = cyc_q;
    slot_d           = slot_q;
    cmd_d            = cmd_q;
    tag_cur_d        = tag_cur_q;
    tag_h0_d         = tag_h0_q;
    tag_h1_d         = tag_h1_q;
    mbox_full_d      = mbox_full_q;
    mbox_d           = mbox_q;
    frame_cnt_d      = frame_cnt_q;
    sample_d         = sample_q;
    sample_ch_d      = sample_ch_q;
    sample_vld_d     = 1'b0;
    host_reply_d     = host_reply_q;
    host_reply_vld_d = 1'b0;

    // Consumption needs a full mailbox and acceptance needs an empty one, so the two never collide.
    // A command accepted during an aux c=0 therefore waits for the next aux slot.
    if (slot_start && take_host) mbox_full_d = 1'b0;
    if (host_cmd_valid_i && !mbox_full_q) begin
      mbox_full_d = 1'b1;
      mbox_d      = host_cmd_i;
    end

    if (slot_start) begin
      cmd_d     = sel_cmd;
      tag_h1_d  = tag_h0_q;
      tag_h0_d  = tag_cur_q;
      tag_cur_d = '{vld: 1'b1, kind: sel_kind, ch: slot_ch};
    end

    if (active) cyc_d = slot_end ? '0 : cyc_q + CW'(1);

    if (slot_end && tag_h1_q.vld) begin
      case (tag_h1_q.kind)
        K_CONV: begin
          sample_d     = spi_reply_i;
          sample_ch_d  = tag_h1_q.ch;
          sample_vld_d = 1'b1;
        end
        K_HOST: begin
          host_reply_d     = spi_reply_i;
          host_reply_vld_d = 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d   = S_RUN;
          cyc_d     = '0;
          slot_d    = '0;
          tag_cur_d = '0;
          tag_h0_d  = '0;
          tag_h1_d  = '0;
        end
      end
      S_RUN: begin
        if (slot_end) begin
          if (slot_q == LAST_SLOT) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            slot_d      = '0;
            if (!enable_i) state_d = S_FLUSH;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (slot_end) begin
          if (slot_q == FLUSH_LAST) begin
            state_d = S_IDLE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= S_IDLE;
      cyc_q            <= '0;
      slot_q           <= '0;
      cmd_q            <= DUMMY_CMD;
      tag_cur_q        <= '0;
      tag_h0_q         <= '0;
      tag_h1_q         <= '0;
      mbox_full_q      <= 1'b0;
      mbox_q           <= '0;
      frame_cnt_q      <= '0;
      sample_q         <= '0;
      sample_ch_q      <= '0;
      sample_vld_q     <= 1'b0;
      host_reply_q     <= '0;
      host_reply_vld_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cyc_q            <= cyc_d;
      slot_q           <= slot_d;
      cmd_q            <= cmd_d;
      tag_cur_q        <= tag_cur_d;
      tag_h0_q         <= tag_h0_d;
      tag_h1_q         <= tag_h1_d;
      mbox_full_q      <= mbox_full_d;
      mbox_q           <= mbox_d;
      frame_cnt_q      <= frame_cnt_d;
      sample_q         <= sample_d;
      sample_ch_q      <= sample_ch_d;
      sample_vld_q     <= sample_vld_d;
      host_reply_q     <= host_reply_d;
      host_reply_vld_q <= host_reply_vld_d;
    end
  end

  assign spi_cmd_o          = slot_start ? sel_cmd : cmd_q;
  assign spi_sync_o         = slot_start;
  assign frame_start_o      = slot_start && (state_q == S_RUN) && (slot_q == '0);
  assign host_cmd_ready_o   = !mbox_full_q;
  assign host_reply_o       = host_reply_q;
  assign host_reply_valid_o = host_reply_vld_q;
  assign sample_o           = sample_q;
  assign sample_ch_o        = sample_ch_q;
  assign sample_valid_o     = sample_vld_q;
  assign frame_cnt_o        = frame_cnt_q;
  assign busy_o             = active;

endmodule
